fetch_sequencer: RTL and testbench

- Instruction-fetch controller. It is the driving end of the program counter interface: it consumes the PC's count and issues LoadPC / IncPC / new_count back to it.
- Reads 16-bit instructions from instruction memory at the current PC. Resolves JMP and HALT locally. Hands ALU instructions to the execute stage over a valid/ready handshake.
- Accepts taken-branch redirects from the execute stage.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/fetch_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, default widths and the fetch-sequencer state encoding.
package cpu_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_INSTR_W     = 16;
    localparam int DEF_MEM_TIMEOUT = 15;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SHFL = 4'b1011;
    localparam logic [3:0] OP_SHFR = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_DECODE   = 3'd3,
        ST_ISSUE    = 3'd4,
        ST_HALTED   = 3'd5
    } fetch_state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        logic r_alu;
        case (op)
            OP_ADD, OP_SUB, OP_NOR, OP_SHFL, OP_SHFR: r_alu = 1'b1;
            default:                                  r_alu = 1'b0;
        endcase
        return r_alu;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the program counter, reads instruction memory,
// resolves JMP/HALT locally and hands ALU instructions to execute over valid/ready.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  count,
    output logic               LoadPC,
    output logic               IncPC,
    output logic [ADDR_W-1:0]  new_count,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               branch_req,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               halt,
    output logic               mem_err
);

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    fetch_state_t       r_state;
    logic [INSTR_W-1:0] r_ir;
    logic               r_ir_valid;
    logic               r_imem_rd;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic               r_halt;
    logic               r_mem_err;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_discard;
    logic [ADDR_W-1:0]  r_tgt;

    logic [3:0]         w_opcode;
    logic               w_mem_done;
    logic               w_redirect;
    logic               w_load_pc;
    logic               w_inc_pc;
    logic [ADDR_W-1:0]  w_new_count;

    assign w_opcode   = r_ir[INSTR_W-1 -: 4];
    // The fetch ends on data or on the last allowed waiting cycle.
    assign w_mem_done = imem_valid || (r_cnt == TMO_LAST);
    assign w_redirect = branch_req || r_discard;

    // PC control decode from current state, registered IR/target and redirect inputs.
    always_comb begin
        w_load_pc   = 1'b0;
        w_inc_pc    = 1'b0;
        w_new_count = '0;
        case (r_state)
            ST_IDLE, ST_FETCH: begin
                if (branch_req) begin
                    w_load_pc   = 1'b1;
                    w_new_count = branch_target;
                end else begin
                    w_load_pc   = 1'b0;
                end
            end
            ST_WAIT_MEM: begin
                if (w_mem_done && w_redirect) begin
                    w_load_pc   = 1'b1;
                    w_new_count = branch_req ? branch_target : r_tgt;
                end else begin
                    w_load_pc   = 1'b0;
                end
            end
            ST_DECODE: begin
                if (branch_req) begin
                    w_load_pc   = 1'b1;
                    w_new_count = branch_target;
                end else if (w_opcode == OP_JMP) begin
                    w_load_pc   = 1'b1;
                    w_new_count = r_ir[ADDR_W-1:0];
                end else if (!is_alu_op(w_opcode) && (w_opcode != OP_HALT)) begin
                    w_inc_pc    = 1'b1;
                end else begin
                    w_inc_pc    = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (branch_req) begin
                    w_load_pc   = 1'b1;
                    w_new_count = branch_target;
                end else if (ir_ready) begin
                    w_inc_pc    = 1'b1;
                end else begin
                    w_inc_pc    = 1'b0;
                end
            end
            default: begin
                w_load_pc = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered memory, issue, halt and error outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_imem_rd   <= 1'b0;
            r_imem_addr <= '0;
            r_halt      <= 1'b0;
            r_mem_err   <= 1'b0;
            r_cnt       <= '0;
            r_discard   <= 1'b0;
            r_tgt       <= '0;
        end else begin
            r_imem_rd <= 1'b0;
            r_mem_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_cnt     <= '0;
                    r_discard <= 1'b0;
                    // A redirect here re-fetches from the new PC without a stray read.
                    if (branch_req) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_imem_rd   <= 1'b1;
                        r_imem_addr <= count;
                        r_state     <= ST_WAIT_MEM;
                    end
                end
                ST_WAIT_MEM: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_mem_done) begin
                        r_discard <= 1'b0;
                        if (w_redirect) begin
                            r_state <= ST_FETCH;
                        end else if (imem_valid) begin
                            r_ir    <= imem_rdata;
                            r_state <= ST_DECODE;
                        end else begin
                            r_mem_err <= 1'b1;
                            r_state   <= ST_FETCH;
                        end
                    end else if (branch_req) begin
                        r_tgt     <= branch_target;
                        r_discard <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT_MEM;
                    end
                end
                ST_DECODE: begin
                    if (branch_req || (w_opcode == OP_JMP)) begin
                        r_state <= ST_FETCH;
                    end else if (w_opcode == OP_HALT) begin
                        r_halt  <= 1'b1;
                        r_state <= ST_HALTED;
                    end else if (is_alu_op(w_opcode)) begin
                        r_ir_valid <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_ISSUE: begin
                    if (branch_req || ir_ready) begin
                        r_ir_valid <= 1'b0;
                        r_state    <= ST_FETCH;
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_HALTED: begin
                    r_halt <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign LoadPC    = w_load_pc;
    assign IncPC     = w_inc_pc;
    assign new_count = w_new_count;
    assign imem_addr = r_imem_addr;
    assign imem_rd   = r_imem_rd;
    assign ir_out    = r_ir;
    assign ir_valid  = r_ir_valid;
    assign halt      = r_halt;
    assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: program-counter and memory models plus
// an architectural reference of which instructions must reach execute.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  count;
    logic        LoadPC, IncPC;
    logic [7:0]  new_count, imem_addr;
    logic        imem_rd;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] ir_out;
    logic        ir_valid, ir_ready, branch_req;
    logic [7:0]  branch_target;
    logic        halt, mem_err;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .count(count), .LoadPC(LoadPC), .IncPC(IncPC),
        .new_count(new_count), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .ir_out(ir_out),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .branch_req(branch_req),
        .branch_target(branch_target), .halt(halt), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];
    int          mem_lat;
    bit          mem_withhold;
    bit          pend;
    int          p_dly;
    logic [7:0]  p_addr;

    logic [7:0]  rd_q[$];
    logic [7:0]  load_q[$];
    logic [15:0] iss_q[$];
    int          rd_cyc[$];
    int          inc_n, irv_n, err_n, err_cyc, cyc_n, both_total;

    logic [3:0]  ops [9] = '{4'h1, 4'h2, 4'h3, 4'hB, 4'hC, 4'h8, 4'h4, 4'h0, 4'hD};

    // Program counter model: load wins, otherwise increment.
    always @(posedge clk or negedge reset) begin
        if (!reset)      count <= 8'h00;
        else if (LoadPC) count <= new_count;
        else if (IncPC)  count <= count + 8'h01;
    end

    // Instruction memory: answers each read after mem_lat cycles (0 = random 1..4).
    always @(negedge clk) begin
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                p_dly = p_dly - 1;
                if (p_dly == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem[p_addr];
                    pend       = 1'b0;
                end
            end
            if (imem_rd && !mem_withhold) begin
                pend   = 1'b1;
                p_addr = imem_addr;
                p_dly  = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
            end
        end
    end

    task automatic clr();
        rd_q.delete(); load_q.delete(); iss_q.delete(); rd_cyc.delete();
        inc_n = 0; irv_n = 0; err_n = 0; err_cyc = -1; cyc_n = 0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        reset = 1'b0; branch_req = 1'b0; ir_ready = 1'b0; mem_withhold = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clr();
    endtask

    // One clock cycle: drive inputs mid-cycle, then log what the DUT shows.
    task automatic cyc(input logic br, input logic [7:0] bt, input logic rdy, input logic br_iv);
        @(negedge clk); #1;
        branch_req    = br | (br_iv & ir_valid);
        branch_target = bt;
        ir_ready      = rdy;
        #1;
        if (imem_rd) begin rd_q.push_back(imem_addr); rd_cyc.push_back(cyc_n); end
        if (LoadPC) load_q.push_back(new_count);
        if (IncPC) inc_n++;
        if (LoadPC && IncPC) both_total++;
        if (ir_valid) irv_n++;
        if (ir_valid && ir_ready && !branch_req) iss_q.push_back(ir_out);
        if (mem_err) begin err_n++; err_cyc = cyc_n; end
        cyc_n++;
    endtask

    task automatic test_reset();
        reset = 1'b0; branch_req = 1'b0; ir_ready = 1'b0; branch_target = 8'h00;
        #3;
        total++;
        if ({imem_rd, ir_valid, halt, mem_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {imem_rd, ir_valid, halt, mem_err});
        end
        total++;
        if ({LoadPC, IncPC, new_count} !== 10'h000) begin
            bad++; $display("FAIL reset_pcctl: got %h want 000", {LoadPC, IncPC, new_count});
        end
        repeat (3) @(negedge clk);
        total++;
        if ({ir_out, imem_addr, imem_rd} !== 25'h0) begin
            bad++; $display("FAIL reset_held: got %h want 0", {ir_out, imem_addr, imem_rd});
        end
    endtask

    task automatic test_add();
        do_reset(); fill_halt();
        mem[0] = 16'h1123; mem_lat = 2;
        for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if (iss_q.size() != 1 || iss_q[0] !== 16'h1123) begin
            bad++; $display("FAIL add_issue: got n=%0d first=%h want n=1 first=1123", iss_q.size(), iss_q[0]);
        end
        total++;
        if (irv_n != 1 || inc_n != 1) begin
            bad++; $display("FAIL add_pulses: got valid=%0d inc=%0d want 1 1", irv_n, inc_n);
        end
        total++;
        if (rd_q.size() < 2 || rd_q[0] !== 8'h00 || rd_q[1] !== 8'h01) begin
            bad++; $display("FAIL add_next_addr: got %h,%h want 00,01", rd_q[0], rd_q[1]);
        end
        total++;
        if (load_q.size() != 0 || halt !== 1'b1) begin
            bad++; $display("FAIL add_tail: got loads=%0d halt=%b want 0 1", load_q.size(), halt);
        end
    endtask

    task automatic test_jmp();
        do_reset(); fill_halt();
        mem[0] = 16'h8011; mem[8'h11] = 16'hF000; mem[1] = 16'h1999; mem_lat = 1;
        for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if (load_q.size() != 1 || load_q[0] !== 8'h11) begin
            bad++; $display("FAIL jmp_load: got n=%0d val=%h want n=1 val=11", load_q.size(), load_q[0]);
        end
        total++;
        if (irv_n != 0 || inc_n != 0) begin
            bad++; $display("FAIL jmp_no_issue: got valid=%0d inc=%0d want 0 0", irv_n, inc_n);
        end
        total++;
        if (rd_q.size() < 2 || rd_q[1] !== 8'h11) begin
            bad++; $display("FAIL jmp_refetch: got %h want 11", rd_q[1]);
        end
    endtask

    task automatic test_stall();
        int hold = 0, unstable = 0, early = 0;
        logic rdy;
        do_reset(); fill_halt();
        mem[0] = 16'h2055; mem_lat = 1;
        for (int i = 0; i < 40; i++) begin
            rdy = (hold >= 4);
            cyc(1'b0, 8'h00, rdy, 1'b0);
            if (ir_valid) begin
                hold++;
                if (ir_out !== 16'h2055) unstable++;
            end
            if (IncPC && !rdy) early++;
        end
        total++;
        if (irv_n != 5 || unstable != 0) begin
            bad++; $display("FAIL stall_hold: got valid=%0d unstable=%0d want 5 0", irv_n, unstable);
        end
        total++;
        if (early != 0 || inc_n != 1 || iss_q.size() != 1) begin
            bad++; $display("FAIL stall_inc: got early=%0d inc=%0d issued=%0d want 0 1 1", early, inc_n, iss_q.size());
        end
    endtask

    task automatic test_branch_wait();
        int br_at = -1, lp_bad = 0;
        do_reset(); fill_halt();
        mem[0] = 16'h1AAA; mem[8'h40] = 16'hF000; mem_lat = 4;
        for (int i = 0; i < 40; i++) begin
            cyc(i == br_at, 8'h40, 1'b1, 1'b0);
            if (imem_rd && br_at < 0) br_at = i + 1;
            if (LoadPC && !imem_valid) lp_bad++;
        end
        total++;
        if (iss_q.size() != 0 || irv_n != 0) begin
            bad++; $display("FAIL brw_dropped: got issued=%0d valid=%0d want 0 0", iss_q.size(), irv_n);
        end
        total++;
        if (load_q.size() != 1 || load_q[0] !== 8'h40 || lp_bad != 0) begin
            bad++; $display("FAIL brw_load: got n=%0d val=%h off_data=%0d want 1 40 0", load_q.size(), load_q[0], lp_bad);
        end
        total++;
        if (err_n != 0 || rd_q.size() < 2 || rd_q[1] !== 8'h40) begin
            bad++; $display("FAIL brw_refetch: got err=%0d addr=%h want 0 40", err_n, rd_q[1]);
        end
    endtask

    task automatic test_branch_overwrite();
        int rd_i = -1;
        do_reset(); fill_halt();
        mem[0] = 16'h1AAA; mem[8'h40] = 16'h1111; mem[8'h50] = 16'hF000; mem_lat = 6;
        for (int i = 0; i < 40; i++) begin
            cyc((rd_i >= 0) && (i == rd_i + 1 || i == rd_i + 3), (i == rd_i + 1) ? 8'h40 : 8'h50, 1'b1, 1'b0);
            if (imem_rd && rd_i < 0) rd_i = i;
        end
        total++;
        if (load_q.size() != 1 || load_q[0] !== 8'h50 || iss_q.size() != 0) begin
            bad++; $display("FAIL brw2_target: got n=%0d val=%h issued=%0d want 1 50 0", load_q.size(), load_q[0], iss_q.size());
        end
        total++;
        if (rd_q.size() < 2 || rd_q[1] !== 8'h50 || halt !== 1'b1) begin
            bad++; $display("FAIL brw2_refetch: got addr=%h halt=%b want 50 1", rd_q[1], halt);
        end
    endtask

    task automatic test_branch_issue();
        bit done = 1'b0;
        do_reset(); fill_halt();
        mem[0] = 16'h1234; mem[8'h60] = 16'hF000; mem_lat = 1;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 8'h60, 1'b1, !done);
            if (branch_req) done = 1'b1;
        end
        total++;
        if (iss_q.size() != 0 || inc_n != 0 || irv_n != 1) begin
            bad++; $display("FAIL bri_cancel: got issued=%0d inc=%0d valid=%0d want 0 0 1", iss_q.size(), inc_n, irv_n);
        end
        total++;
        if (load_q.size() != 1 || load_q[0] !== 8'h60 || rd_q.size() < 2 || rd_q[1] !== 8'h60) begin
            bad++; $display("FAIL bri_redirect: got load=%h addr=%h want 60 60", load_q[0], rd_q[1]);
        end
    endtask

    task automatic test_timeout();
        do_reset(); fill_halt();
        mem_lat = 1; mem_withhold = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            if (mem_err) mem_withhold = 1'b0;
        end
        total++;
        if (err_n != 1 || rd_cyc.size() < 1 || err_cyc - rd_cyc[0] != 15) begin
            bad++; $display("FAIL tmo_err: got pulses=%0d delay=%0d want 1 15", err_n, err_cyc - rd_cyc[0]);
        end
        total++;
        if (rd_q.size() < 2 || rd_q[0] !== 8'h00 || rd_q[1] !== 8'h00) begin
            bad++; $display("FAIL tmo_retry: got %h,%h want 00,00", rd_q[0], rd_q[1]);
        end
        total++;
        if (load_q.size() != 0 || inc_n != 0 || halt !== 1'b1) begin
            bad++; $display("FAIL tmo_pc: got loads=%0d inc=%0d halt=%b want 0 0 1", load_q.size(), inc_n, halt);
        end
    endtask

    task automatic test_halt();
        do_reset(); fill_halt();
        mem_lat = 1;
        for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        clr();
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'h33, 1'b1, 1'b0);
        total++;
        if (halt !== 1'b1 || load_q.size() != 0 || rd_q.size() != 0 || inc_n != 0) begin
            bad++; $display("FAIL halt_hold: got halt=%b loads=%0d reads=%0d inc=%0d want 1 0 0 0", halt, load_q.size(), rd_q.size(), inc_n);
        end
        branch_req = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (halt !== 1'b0 || ir_valid !== 1'b0) begin
            bad++; $display("FAIL halt_async_rst: got halt=%b valid=%b want 0 0", halt, ir_valid);
        end
        @(negedge clk);
        mem[0] = 16'h3055;
        reset = 1'b1;
        clr();
        for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if (rd_q.size() < 1 || rd_q[0] !== 8'h00 || iss_q.size() != 1 || iss_q[0] !== 16'h3055 || halt !== 1'b1) begin
            bad++; $display("FAIL halt_restart: got addr=%h issued=%0d ir=%h halt=%b want 00 1 3055 1", rd_q[0], iss_q.size(), iss_q[0], halt);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_q[$];
        logic [15:0] ins;
        logic [3:0]  op;
        logic [7:0]  pc;
        bit          stop;
        int          nbad;
        for (int it = 0; it < 4; it++) begin
            do_reset(); fill_halt();
            mem_lat = 0;
            for (int a = 0; a < 32; a++) begin
                op = ops[$urandom_range(0, 8)];
                mem[a] = {op, 4'($urandom_range(0, 15)),
                          (op == 4'h8) ? 8'($urandom_range(a + 1, 32)) : 8'($urandom_range(0, 255))};
            end
            exp_q.delete(); pc = 8'h00; stop = 1'b0;
            for (int s = 0; s < 200 && !stop; s++) begin
                ins = mem[pc];
                if (ins[15:12] inside {4'h1, 4'h2, 4'h3, 4'hB, 4'hC}) begin
                    exp_q.push_back(ins); pc = pc + 8'h01;
                end else if (ins[15:12] == 4'h8) pc = ins[7:0];
                else if (ins[15:12] == 4'hF) stop = 1'b1;
                else pc = pc + 8'h01;
            end
            for (int c = 0; c < 1500 && !halt; c++) cyc(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
            nbad = (iss_q.size() != exp_q.size()) ? 1 : 0;
            if (nbad == 0) foreach (exp_q[k]) if (iss_q[k] !== exp_q[k]) nbad++;
            total++;
            if (nbad != 0 || halt !== 1'b1) begin
                bad++; $display("FAIL rand_stream%0d: got n=%0d halt=%b want n=%0d halt=1", it, iss_q.size(), halt, exp_q.size());
            end
        end
    endtask

    initial begin
        imem_valid = 1'b0; imem_rdata = 16'h0000; mem_lat = 1; mem_withhold = 1'b0;
        both_total = 0; pend = 1'b0; p_dly = 0; p_addr = 8'h00;
        clr();
        test_reset();
        test_add();
        test_jmp();
        test_stall();
        test_branch_wait();
        test_branch_overwrite();
        test_branch_issue();
        test_timeout();
        test_halt();
        test_random();
        total++;
        if (both_total != 0) begin
            bad++; $display("FAIL load_inc_overlap: got %0d want 0", both_total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
